// File: rtl/vga_pkg.sv
// Shared types for the VGA timing generator.
//   vga_cfg_t       : one complete timing mode (12-bit fields, 96 bits total).
//   vga_640x480_cfg : standard 640x480 timing (800 x 521 totals).
package vga_pkg;

  typedef struct packed {
    logic [11:0] hcnt;  // visible pixels per line
    logic [11:0] hfp;   // horizontal front porch
    logic [11:0] hsp;   // horizontal sync width
    logic [11:0] hbp;   // horizontal back porch
    logic [11:0] vcnt;  // visible lines per frame
    logic [11:0] vfp;   // vertical front porch
    logic [11:0] vsp;   // vertical sync width
    logic [11:0] vbp;   // vertical back porch
  } vga_cfg_t;

  localparam vga_cfg_t vga_640x480_cfg = '{
    hcnt: 12'd640, hfp: 12'd16, hsp: 12'd96, hbp: 12'd48,
    vcnt: 12'd480, vfp: 12'd10, vsp: 12'd2,  vbp: 12'd29
  };

endpackage

// File: rtl/vga_timing_gen.sv
// VGA timing generator with run-time mode switching.
//
// Ports:
//   clk                  pixel clock
//   rst                  synchronous active-high reset
//   en                   count enable; counters freeze while low
//   cfg                  requested timing mode (vga_pkg::vga_cfg_t)
//   cfg_hpol, cfg_vpol   requested sync polarities (1 = active-high)
//   cfg_valid            single-cycle request to stage cfg/polarities
//   cfg_ack              pulse together with the frame_start of a newly applied mode
//   cfg_err              pulse one cycle after a rejected request
//   hsync, vsync         sync outputs with polarity applied
//   disp_en              high inside the visible area
//   hpos, vpos           current column / row
//   line_start           pulse at column 0
//   frame_start          pulse at (0,0)
//
// Line order is active, front porch, sync, back porch (same vertically).
// All outputs are registered one cycle behind the h/v counter state.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter vga_cfg_t DEFAULT_CFG  = vga_640x480_cfg,
  parameter logic     DEFAULT_HPOL = 1'b0,
  parameter logic     DEFAULT_VPOL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  vga_cfg_t    cfg,
  input  logic        cfg_hpol,
  input  logic        cfg_vpol,
  input  logic        cfg_valid,
  output logic        cfg_ack,
  output logic        cfg_err,
  output logic        hsync,
  output logic        vsync,
  output logic        disp_en,
  output logic [11:0] hpos,
  output logic [11:0] vpos,
  output logic        line_start,
  output logic        frame_start
);

  // Modes are kept as precomputed boundaries so the per-pixel compare path
  // carries no adders.
  typedef struct packed {
    logic [11:0] h_act;   // first non-visible column
    logic [11:0] hs_beg;  // first sync column
    logic [11:0] hs_end;  // first column after sync
    logic [11:0] h_last;  // HT-1
    logic [11:0] v_act;
    logic [11:0] vs_beg;
    logic [11:0] vs_end;
    logic [11:0] v_last;  // VT-1
  } tim_t;

  function automatic tim_t derive(input vga_cfg_t c);
    tim_t t;
    t.h_act  = c.hcnt;
    t.hs_beg = c.hcnt + c.hfp;
    t.hs_end = t.hs_beg + c.hsp;
    t.h_last = t.hs_end + c.hbp - 12'd1;
    t.v_act  = c.vcnt;
    t.vs_beg = c.vcnt + c.vfp;
    t.vs_end = t.vs_beg + c.vsp;
    t.v_last = t.vs_end + c.vbp - 12'd1;
    return t;
  endfunction

  localparam tim_t DEFAULT_TIM = derive(DEFAULT_CFG);

  // Active mode, pending mode and counters
  tim_t        r_act;
  logic        r_hpol;
  logic        r_vpol;
  tim_t        r_pend;
  logic        r_pend_hpol;
  logic        r_pend_vpol;
  logic        r_pending;
  logic        r_ack_due;
  logic [11:0] r_h;
  logic [11:0] r_v;

  // Registered outputs
  logic        r_cfg_ack;
  logic        r_cfg_err;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_disp_en;
  logic [11:0] r_hpos;
  logic [11:0] r_vpos;
  logic        r_line_start;
  logic        r_frame_start;

  // Request validation (totals computed wide so 12-bit overflow is caught)
  logic [13:0] w_ht;
  logic [13:0] w_vt;
  logic        w_req_bad;
  tim_t        w_req_tim;

  // Counter decode
  logic        w_h_last;
  logic        w_v_last;
  logic        w_wrap;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_vis;

  always_comb begin
    w_ht      = 14'(cfg.hcnt) + 14'(cfg.hfp) + 14'(cfg.hsp) + 14'(cfg.hbp);
    w_vt      = 14'(cfg.vcnt) + 14'(cfg.vfp) + 14'(cfg.vsp) + 14'(cfg.vbp);
    w_req_bad = (cfg.hcnt == '0) || (cfg.hsp == '0) ||
                (cfg.vcnt == '0) || (cfg.vsp == '0) ||
                (w_ht > 14'd4095) || (w_vt > 14'd4095);
    w_req_tim = derive(cfg);
  end

  always_comb begin
    w_h_last = (r_h == r_act.h_last);
    w_v_last = (r_v == r_act.v_last);
    w_wrap   = w_h_last && w_v_last;
    w_hs_act = (r_h >= r_act.hs_beg) && (r_h < r_act.hs_end);
    w_vs_act = (r_v >= r_act.vs_beg) && (r_v < r_act.vs_end);
    w_vis    = (r_h < r_act.h_act) && (r_v < r_act.v_act);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act         <= DEFAULT_TIM;
      r_hpol        <= DEFAULT_HPOL;
      r_vpol        <= DEFAULT_VPOL;
      r_pend        <= DEFAULT_TIM;
      r_pend_hpol   <= DEFAULT_HPOL;
      r_pend_vpol   <= DEFAULT_VPOL;
      r_pending     <= 1'b0;
      r_ack_due     <= 1'b0;
      r_h           <= '0;
      r_v           <= '0;
      r_cfg_ack     <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_hsync       <= ~DEFAULT_HPOL;
      r_vsync       <= ~DEFAULT_VPOL;
      r_disp_en     <= 1'b0;
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_cfg_err <= cfg_valid && w_req_bad;

      if (en) begin
        // Outputs reflect the counter state of this cycle.
        r_hpos        <= r_h;
        r_vpos        <= r_v;
        r_disp_en     <= w_vis;
        r_hsync       <= ~(w_hs_act ^ r_hpol);
        r_vsync       <= ~(w_vs_act ^ r_vpol);
        r_line_start  <= (r_h == '0);
        r_frame_start <= (r_h == '0) && (r_v == '0);
        // r_ack_due is only set on a wrap, so the state here is (0,0) and
        // the ack lands on the same output cycle as frame_start.
        r_cfg_ack     <= r_ack_due;
        r_ack_due     <= 1'b0;

        if (w_h_last) begin
          r_h <= '0;
          r_v <= w_v_last ? '0 : r_v + 12'd1;
        end else begin
          r_h <= r_h + 12'd1;
        end

        // Mode switch only on the frame wrap. A request arriving in this
        // same cycle is written below and waits for the next wrap, since
        // r_pend here still holds the previously staged value.
        if (w_wrap && r_pending) begin
          r_act     <= r_pend;
          r_hpol    <= r_pend_hpol;
          r_vpol    <= r_pend_vpol;
          r_pending <= 1'b0;
          r_ack_due <= 1'b1;
        end
      end else begin
        r_disp_en     <= 1'b0;
        r_hsync       <= ~r_hpol;
        r_vsync       <= ~r_vpol;
        r_line_start  <= 1'b0;
        r_frame_start <= 1'b0;
        r_cfg_ack     <= 1'b0;
      end

      // Latest accepted request wins; overrides the pending clear above.
      if (cfg_valid && !w_req_bad) begin
        r_pend      <= w_req_tim;
        r_pend_hpol <= cfg_hpol;
        r_pend_vpol <= cfg_vpol;
        r_pending   <= 1'b1;
      end
    end
  end

  assign cfg_ack     = r_cfg_ack;
  assign cfg_err     = r_cfg_err;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign disp_en     = r_disp_en;
  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen.
// u_small runs a tiny default mode (16 x 9 totals) so whole frames and mode
// switches stay short; u_def runs the stock 640x480 default for one line.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam vga_cfg_t SMALL = '{hcnt: 12'd8, hfp: 12'd2, hsp: 12'd3, hbp: 12'd3,
                                 vcnt: 12'd4, vfp: 12'd1, vsp: 12'd2, vbp: 12'd2};
  localparam vga_cfg_t MODE_B = '{hcnt: 12'd6, hfp: 12'd1, hsp: 12'd2, hbp: 12'd1,
                                  vcnt: 12'd3, vfp: 12'd1, vsp: 12'd1, vbp: 12'd1};
  localparam vga_cfg_t MODE_C = '{hcnt: 12'd4, hfp: 12'd1, hsp: 12'd1, hbp: 12'd2,
                                  vcnt: 12'd2, vfp: 12'd1, vsp: 12'd1, vbp: 12'd1};
  localparam vga_cfg_t MODE_D = '{hcnt: 12'd6, hfp: 12'd2, hsp: 12'd2, hbp: 12'd2,
                                  vcnt: 12'd3, vfp: 12'd1, vsp: 12'd1, vbp: 12'd2};
  localparam vga_cfg_t BAD_HSP = '{hcnt: 12'd8, hfp: 12'd2, hsp: 12'd0, hbp: 12'd3,
                                   vcnt: 12'd4, vfp: 12'd1, vsp: 12'd2, vbp: 12'd2};
  localparam vga_cfg_t BAD_HT = '{hcnt: 12'd4000, hfp: 12'd50, hsp: 12'd50, hbp: 12'd50,
                                  vcnt: 12'd4, vfp: 12'd1, vsp: 12'd2, vbp: 12'd2};
  localparam vga_cfg_t BAD_VT = '{hcnt: 12'd8, hfp: 12'd2, hsp: 12'd3, hbp: 12'd3,
                                  vcnt: 12'd4095, vfp: 12'd1, vsp: 12'd1, vbp: 12'd1};

  // u_small signals
  logic s_rst = 1'b1, s_en = 1'b1, s_cfg_valid = 1'b0, s_cfg_hpol = 1'b0, s_cfg_vpol = 1'b0;
  vga_cfg_t s_cfg = SMALL;
  logic s_ack, s_err, s_hs, s_vs, s_de, s_ls, s_fs;
  logic [11:0] s_hpos, s_vpos;

  // u_def signals
  logic d_rst = 1'b1, d_en = 1'b1, d_cfg_valid = 1'b0, d_cfg_hpol = 1'b0, d_cfg_vpol = 1'b0;
  vga_cfg_t d_cfg = vga_640x480_cfg;
  logic d_ack, d_err, d_hs, d_vs, d_de, d_ls, d_fs;
  logic [11:0] d_hpos, d_vpos;

  vga_timing_gen #(
    .DEFAULT_CFG (SMALL),
    .DEFAULT_HPOL(1'b0),
    .DEFAULT_VPOL(1'b0)
  ) u_small (
    .clk(clk), .rst(s_rst), .en(s_en), .cfg(s_cfg), .cfg_hpol(s_cfg_hpol),
    .cfg_vpol(s_cfg_vpol), .cfg_valid(s_cfg_valid), .cfg_ack(s_ack), .cfg_err(s_err),
    .hsync(s_hs), .vsync(s_vs), .disp_en(s_de), .hpos(s_hpos), .vpos(s_vpos),
    .line_start(s_ls), .frame_start(s_fs)
  );

  vga_timing_gen u_def (
    .clk(clk), .rst(d_rst), .en(d_en), .cfg(d_cfg), .cfg_hpol(d_cfg_hpol),
    .cfg_vpol(d_cfg_vpol), .cfg_valid(d_cfg_valid), .cfg_ack(d_ack), .cfg_err(d_err),
    .hsync(d_hs), .vsync(d_vs), .disp_en(d_de), .hpos(d_hpos), .vpos(d_vpos),
    .line_start(d_ls), .frame_start(d_fs)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired, got no event, expected event", name);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Packed view of the small-DUT display outputs: {h, v, hs, vs, de, ls, fs}
  function automatic int s_pack();
    return {3'b0, s_hpos, s_vpos, s_hs, s_vs, s_de, s_ls, s_fs};
  endfunction

  function automatic int mk(input int h, input int v, input bit hs, input bit vs,
                            input bit de, input bit ls, input bit fs);
    return {3'b0, 12'(h), 12'(v), hs, vs, de, ls, fs};
  endfunction

  // Steps to the next frame_start; counts acks seen before it.
  task automatic wait_fs(input string name, output int cycles, output int acks_before);
    cycles = 0;
    acks_before = 0;
    while (1) begin
      step();
      cycles++;
      if (s_fs) break;
      if (s_ack) acks_before++;
      if (cycles >= 400) begin
        fail_timeout(name);
        break;
      end
    end
  endtask

  // From a frame_start, measure one whole frame.
  task automatic frame_stats(input string name, output int period, output int lp,
                             output int acks, output int ack_end);
    period = 0; lp = 0; acks = 0; ack_end = 0;
    while (1) begin
      step();
      period++;
      if (s_ls && lp == 0) lp = period;
      if (s_fs) begin
        ack_end = int'(s_ack);
        break;
      end
      if (s_ack) acks++;
      if (period >= 400) begin
        fail_timeout(name);
        break;
      end
    end
  endtask

  task automatic step_until(input string name, input int h, input int v, output int n);
    n = 0;
    while (1) begin
      step();
      n++;
      if ((h < 0 || int'(s_hpos) == h) && int'(s_vpos) == v) break;
      if (n >= 400) begin
        fail_timeout(name);
        break;
      end
    end
  endtask

  task automatic send(input vga_cfg_t c, input bit hp, input bit vp);
    s_cfg = c; s_cfg_hpol = hp; s_cfg_vpol = vp; s_cfg_valid = 1'b1;
    step();
    s_cfg_valid = 1'b0;
  endtask

  typedef struct {
    int t;
    int exp;
  } vec_t;

  vec_t vecs[16];
  vga_cfg_t bad[3];

  initial begin
    int vi, per, lp, acks, ack_end, n, cyc, hs_low, hs_first, hs_last, de_cnt;
    bit quiet;

    vecs[0]  = '{0,   mk(0, 0, 1, 1, 1, 1, 1)};
    vecs[1]  = '{7,   mk(7, 0, 1, 1, 1, 0, 0)};
    vecs[2]  = '{8,   mk(8, 0, 1, 1, 0, 0, 0)};
    vecs[3]  = '{9,   mk(9, 0, 1, 1, 0, 0, 0)};
    vecs[4]  = '{10,  mk(10, 0, 0, 1, 0, 0, 0)};
    vecs[5]  = '{12,  mk(12, 0, 0, 1, 0, 0, 0)};
    vecs[6]  = '{13,  mk(13, 0, 1, 1, 0, 0, 0)};
    vecs[7]  = '{15,  mk(15, 0, 1, 1, 0, 0, 0)};
    vecs[8]  = '{16,  mk(0, 1, 1, 1, 1, 1, 0)};
    vecs[9]  = '{63,  mk(15, 3, 1, 1, 0, 0, 0)};
    vecs[10] = '{64,  mk(0, 4, 1, 1, 0, 1, 0)};
    vecs[11] = '{80,  mk(0, 5, 1, 0, 0, 1, 0)};
    vecs[12] = '{111, mk(15, 6, 1, 0, 0, 0, 0)};
    vecs[13] = '{112, mk(0, 7, 1, 1, 0, 1, 0)};
    vecs[14] = '{143, mk(15, 8, 1, 1, 0, 0, 0)};
    vecs[15] = '{144, mk(0, 0, 1, 1, 1, 1, 1)};
    bad[0] = BAD_HSP; bad[1] = BAD_HT; bad[2] = BAD_VT;

    // Reset state
    repeat (3) step();
    chk("small_reset_outputs", s_pack(), mk(0, 0, 1, 1, 0, 0, 0));
    chk("small_reset_ack_err", {s_ack, s_err}, 0);
    chk("def_reset_outputs", {d_hpos, d_vpos, d_hs, d_vs, d_de, d_ls, d_fs, d_ack, d_err},
        {12'd0, 12'd0, 7'b1100000});

    // Table vectors over one full small frame (t = output position index)
    s_rst = 1'b0;
    vi = 0;
    for (int t = 0; t <= 144; t++) begin
      step();
      if (vi < 16 && vecs[vi].t == t) begin
        chk($sformatf("vec_t%0d", t), s_pack(), vecs[vi].exp);
        vi++;
      end
    end

    // Rejected requests: err one cycle later, then quiet
    for (int i = 0; i < 3; i++) begin
      send(bad[i], 1'b1, 1'b1);
      chk($sformatf("err_pulse%0d", i), int'(s_err), 1);
      step();
      chk($sformatf("err_clear%0d", i), int'(s_err), 0);
    end
    wait_fs("err_wait_fs", cyc, acks);
    chk("err_no_ack_fs", int'(s_ack), 0);
    frame_stats("err_frame", per, lp, acks, ack_end);
    chk("err_frame_period", per, 144);
    chk("err_line_period", lp, 16);
    chk("err_acks", acks + ack_end, 0);

    // Mid-frame switch to MODE_B, active-high syncs
    step_until("b_to_v3", -1, 3, n);
    send(MODE_B, 1'b1, 1'b1);
    chk("b_no_err", int'(s_err), 0);
    wait_fs("b_wait_fs", cyc, acks);
    chk("b_old_frame_len", n + 1 + cyc, 144);
    chk("b_no_early_ack", acks, 0);
    chk("b_ack_with_fs", int'(s_ack), 1);
    chk("b_first_px", s_pack(), mk(0, 0, 0, 0, 1, 1, 1));
    repeat (7) step();
    chk("b_hs_h7", {s_hpos, s_hs}, {12'd7, 1'b1});
    repeat (2) step();
    chk("b_hs_h9", {s_hpos, s_hs}, {12'd9, 1'b0});
    wait_fs("b_wait_fs2", cyc, acks);
    frame_stats("b_frame", per, lp, acks, ack_end);
    chk("b_frame_period", per, 60);
    chk("b_line_period", lp, 10);
    chk("b_acks", acks + ack_end, 0);

    // Two requests in one frame: only the latest applies, one ack
    repeat (5) step();
    send(MODE_C, 1'b0, 1'b0);
    repeat (20) step();
    send(MODE_D, 1'b1, 1'b1);
    wait_fs("cd_wait_fs", cyc, acks);
    chk("cd_old_frame_len", 5 + 1 + 20 + 1 + cyc, 60);
    chk("cd_no_early_ack", acks, 0);
    chk("cd_single_ack", int'(s_ack), 1);
    frame_stats("d_frame", per, lp, acks, ack_end);
    chk("d_frame_period", per, 84);
    chk("d_line_period", lp, 12);
    chk("d_acks", acks + ack_end, 0);

    // Request in the wrap cycle is deferred to the following wrap
    step_until("wrap_pos", 10, 6, n);
    send(MODE_B, 1'b1, 1'b1);
    chk("wrap_req_pos", {s_hpos, s_vpos}, {12'd11, 12'd6});
    wait_fs("wrap_wait_fs", cyc, acks);
    chk("wrap_no_ack_now", int'(s_ack) + acks, 0);
    frame_stats("wrap_frame1", per, lp, acks, ack_end);
    chk("wrap_frame1_period", per, 84);
    chk("wrap_ack_next", ack_end, 1);
    frame_stats("wrap_frame2", per, lp, acks, ack_end);
    chk("wrap_frame2_period", per, 60);

    // Reset mid-frame with a mode pending
    step_until("rst_v2", -1, 2, n);
    send(MODE_D, 1'b1, 1'b1);
    repeat (3) step();
    s_rst = 1'b1;
    step();
    chk("rst_outputs", s_pack(), mk(0, 0, 1, 1, 0, 0, 0));
    chk("rst_ack_err", {s_ack, s_err}, 0);
    s_rst = 1'b0;
    step();
    chk("rst_first_px", {s_pack(), s_ack}, {mk(0, 0, 1, 1, 1, 1, 1), 1'b0});
    frame_stats("rst_frame", per, lp, acks, ack_end);
    chk("rst_frame_period", per, 144);
    chk("rst_line_period", lp, 16);
    chk("rst_acks", acks + ack_end, 0);

    // Stock 640x480 default: one line
    d_rst = 1'b0;
    hs_low = 0; hs_first = -1; hs_last = -1; de_cnt = 0;
    for (int c = 0; c < 800; c++) begin
      step();
      if (c == 0) chk("def_first_px", {d_hpos, d_vpos, d_ls, d_fs}, {24'd0, 2'b11});
      if (!d_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(d_hpos);
        hs_last = int'(d_hpos);
      end
      if (d_de) de_cnt++;
    end
    chk("def_hs_low_cycles", hs_low, 96);
    chk("def_hs_first", hs_first, 656);
    chk("def_hs_last", hs_last, 751);
    chk("def_de_cycles", de_cnt, 640);
    step();
    chk("def_line2_start", {d_hpos, d_vpos, d_ls, d_fs}, {12'd0, 12'd1, 2'b10});

    // Enable low for 10 cycles once hpos shows 300
    n = 0;
    while (int'(d_hpos) != 300 && n < 400) begin
      step();
      n++;
    end
    if (int'(d_hpos) != 300) fail_timeout("def_reach_h300");
    d_en = 1'b0;
    quiet = 1'b1;
    repeat (10) begin
      step();
      if (d_de || !d_hs || !d_vs || d_ls || d_fs || d_ack) quiet = 1'b0;
    end
    chk("def_en_low_inactive", int'(quiet), 1);
    d_en = 1'b1;
    step();
    chk("def_resume_hpos", int'(d_hpos), 301);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001: Parameter DEFAULT_CFG, default vga_pkg::vga_640x480_cfg; this timing set is active after reset.
REQ-002: Parameter DEFAULT_HPOL, default 0; hsync polarity after reset (0 = active-low, 1 = active-high).
REQ-003: Parameter DEFAULT_VPOL, default 0; vsync polarity after reset, same encoding.
REQ-004: clk  in  1  pixel clock; the only clock.
REQ-005: rst  in  1  synchronous, active-high reset.
REQ-006: en  in  1  count enable; when low, counters freeze.
REQ-007: cfg  in  96  vga_pkg::vga_cfg_t; requested timing, sampled when cfg_valid is high.
REQ-008: cfg_hpol / cfg_vpol  in  1 each  requested sync polarities, sampled with cfg.
REQ-009: cfg_valid  in  1  single-cycle request to stage a new mode.
REQ-010: cfg_ack  out  1  one-cycle pulse in the cycle the staged mode becomes active.
REQ-011: cfg_err  out  1  one-cycle pulse, one cycle after cfg_valid, if the request is rejected.
REQ-012: hsync / vsync  out  1 each  sync outputs, polarity applied.
REQ-013: disp_en  out  1  high inside the visible area.
REQ-014: hpos / vpos  out  12 each  current pixel column and row.
REQ-015: line_start / frame_start  out  1 each  pulse at position (0,y) and at position (0,0).

Function
REQ-016: Horizontal total HT SHALL be hcnt+hfp+hsp+hbp; vertical total VT SHALL be vcnt+vfp+vsp+vbp; arithmetic SHALL be 12-bit and totals above 4095 are rejected.
REQ-017: Internal counters h (0..HT-1) and v (0..VT-1) SHALL advance once per clk while en=1; h wraps to 0 after HT-1, v increments on h wrap and wraps to 0 after VT-1.
REQ-018: Each line SHALL be ordered as active, front porch, sync, back porch; hsync is asserted for hcnt+hfp <= h < hcnt+hfp+hsp; vsync uses the same rule on v.
REQ-019: disp_en SHALL be asserted iff h < hcnt and v < vcnt; hpos/vpos SHALL equal h/v.
REQ-020: All outputs SHALL be registered, with exactly one cycle of latency from the counter state.
REQ-021: Asserted sync SHALL drive the polarity bit value, and deasserted sync its inverse.
REQ-022: While en=0: counters hold, disp_en=0, hsync/vsync inactive, and line_start/frame_start/cfg_ack SHALL NOT pulse.
REQ-023: A cfg_valid request SHALL be rejected (cfg_err, nothing staged) if hcnt, hsp, vcnt or vsp is 0, or if HT or VT exceeds 4095.
REQ-024: An accepted request SHALL be written to a pending register and set a pending flag.
REQ-025: A new cfg_valid while pending SHALL overwrite the pending mode (latest wins), with no ack for the overwritten one.
REQ-026: A pending mode SHALL become active only on the counter wrap from (HT-1,VT-1) to (0,0), never mid-frame.
REQ-027: When the mode becomes active, counters restart at (0,0), cfg_ack pulses aligned with that frame_start, and the pending flag clears.
REQ-028: A cfg_valid in the same cycle as a frame wrap SHALL be applied at the following wrap, not the current one.

Reset
REQ-029: On rst: h=v=0; active mode = DEFAULT_CFG/DEFAULT_HPOL/DEFAULT_VPOL; pending flag clear.
REQ-030: On rst: disp_en=0, hpos=vpos=0, line_start=frame_start=cfg_ack=cfg_err=0, and hsync/vsync at inactive level (1 with default polarities).
REQ-031: The first cycle after rst is released (with en=1) SHALL output position (0,0) one cycle later, with frame_start=1 and line_start=1.
REQ-032: rst asserted mid-frame or with a mode pending SHALL discard the pending mode and restore defaults within one cycle.

Verification
REQ-033: Default 640x480, en=1 for one line -> hsync low exactly for h=656..751 (96 cycles); line period 800; disp_en high for 640 cycles.
REQ-034: Default mode, one full frame -> vsync low for lines 490..491; frame_start period 416800 cycles (800x521).
REQ-035: cfg_valid with 1024x768 at mid-frame (v=100), cfg_hpol=cfg_vpol=1 -> old timing continues to (799,520); then cfg_ack and frame_start together; HT=1344, VT=806; syncs active-high.
REQ-036: cfg_valid with hsp=0 -> cfg_err one cycle later; timing unchanged; no cfg_ack.
REQ-037: Two cfg_valid in one frame (800x600 then 1024x768) -> a single cfg_ack at the wrap; 1024x768 applied.
REQ-038: en low for 10 cycles at h=300 -> outputs inactive, h resumes at 301; rst at v=200 with a mode pending -> defaults restored, no cfg_ack.
